// File: rtl/calc1_port_driver.sv
// calc1_port_driver: queues host commands and issues them one at a time to a
// single calc1 port (two-cycle request: cmd/op1 then 0/op2), then holds the
// calc1 response until the host takes it.
// Optional build macro CALC1_DRV_TIMEOUT_EN: when defined, a WAIT-state
// down-counter completes a command with resp 2'b11 after TIMEOUT_CYCLES
// cycles without a calc1 response. Without it, WAIT lasts until calc1 answers.
//
// state | meaning
// IDLE  | no command in flight; pops the FIFO head when one is queued
// SEND1 | req_cmd_out/req_data_out show cmd/op1 (all zero for cmd 0)
// SEND2 | req_cmd_out/req_data_out show 0/op2
// WAIT  | waiting for a non-zero out_resp from calc1
// HOLD  | rsp_* valid and stable until rsp_ready
module calc1_port_driver #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [3:0]  host_cmd,
  input  logic [31:0] host_op1,
  input  logic [31:0] host_op2,
  input  logic [1:0]  host_tag,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  input  logic [1:0]  out_resp,
  input  logic [31:0] out_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_resp,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_tag,
  output logic        busy,
  output logic        err_spurious
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = 4 + 32 + 32 + 2;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SEND1 = 3'd1;
  localparam logic [2:0] ST_SEND2 = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  logic [2:0]    state;
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt, fifo_cnt_nxt;
  logic          fifo_push, fifo_pop;
  logic [3:0]    rd_cmd;
  logic [31:0]   rd_op1, rd_op2;
  logic [1:0]    rd_tag;
  logic [3:0]    cur_cmd;
  logic [31:0]   cur_op2;
  logic [1:0]    cur_tag;
  logic          wait_expired;

  assign fifo_push = host_valid && host_ready;
  assign fifo_pop  = (state == ST_IDLE) && (fifo_cnt != '0);
  assign {rd_cmd, rd_op1, rd_op2, rd_tag} = fifo_mem[rd_ptr];
  assign busy = (state != ST_IDLE) || (fifo_cnt != '0);

  // next FIFO occupancy from this cycle's push/pop
  always_comb begin
    fifo_cnt_nxt = fifo_cnt;
    if (fifo_push && !fifo_pop)
      fifo_cnt_nxt = fifo_cnt + 1'b1;
    else if (!fifo_push && fifo_pop)
      fifo_cnt_nxt = fifo_cnt - 1'b1;
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge c_clk) begin
    if (fifo_push)
      fifo_mem[wr_ptr] <= {host_cmd, host_op1, host_op2, host_tag};
  end

  // FIFO pointers and occupancy; host_ready is registered from the next
  // occupancy so it reflects "not full" at the start of each cycle
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      host_ready <= 1'b0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt   <= fifo_cnt_nxt;
      host_ready <= (fifo_cnt_nxt != FULL_CNT);
    end
  end

`ifdef CALC1_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_tmr;

  // WAIT timer: loaded on the way into WAIT, terminal count on the last allowed cycle
  always_ff @(posedge c_clk) begin
    if (!reset)
      wait_tmr <= '0;
    else if (state == ST_SEND2)
      wait_tmr <= TW'(TIMEOUT_CYCLES - 1);
    else if (state == ST_WAIT && wait_tmr != '0)
      wait_tmr <= wait_tmr - 1'b1;
  end

  assign wait_expired = (wait_tmr == '0);
`else
  assign wait_expired = 1'b0;
`endif

  // command sequencer: calc1 request drive, response capture, spurious detect
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      req_cmd_out  <= '0;
      req_data_out <= '0;
      rsp_valid    <= 1'b0;
      rsp_resp     <= '0;
      rsp_data     <= '0;
      rsp_tag      <= '0;
      cur_cmd      <= '0;
      cur_op2      <= '0;
      cur_tag      <= '0;
      err_spurious <= 1'b0;
    end else begin
      req_cmd_out  <= '0;
      req_data_out <= '0;
      if (out_resp != 2'b00 && state != ST_WAIT)
        err_spurious <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            cur_cmd <= rd_cmd;
            cur_op2 <= rd_op2;
            cur_tag <= rd_tag;
            state   <= ST_SEND1;
            // cmd 0 never reaches calc1: SEND1 is spent with the port idle
            if (rd_cmd != 4'd0) begin
              req_cmd_out  <= rd_cmd;
              req_data_out <= rd_op1;
            end
          end
        end
        ST_SEND1: begin
          if (cur_cmd == 4'd0) begin
            state     <= ST_HOLD;
            rsp_valid <= 1'b1;
            rsp_resp  <= 2'b10;
            rsp_data  <= '0;
            rsp_tag   <= cur_tag;
          end else begin
            state        <= ST_SEND2;
            req_data_out <= cur_op2;
          end
        end
        ST_SEND2: state <= ST_WAIT;
        ST_WAIT: begin
          if (out_resp != 2'b00) begin
            state     <= ST_HOLD;
            rsp_valid <= 1'b1;
            rsp_resp  <= out_resp;
            rsp_data  <= out_data;
            rsp_tag   <= cur_tag;
          end else if (wait_expired) begin
            state     <= ST_HOLD;
            rsp_valid <= 1'b1;
            rsp_resp  <= 2'b11;
            rsp_data  <= '0;
            rsp_tag   <= cur_tag;
          end
        end
        ST_HOLD: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc1_port_driver.sv
// Bench for calc1_port_driver: directed commands with hand-computed results,
// a small calc1 responder, and a scoreboard monitor on the rsp handshake.
module tb_calc1_port_driver;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
  } exp_t;

  logic        c_clk = 1'b0;
  logic        reset;
  logic        host_valid;
  logic        host_ready;
  logic [3:0]  host_cmd;
  logic [31:0] host_op1, host_op2;
  logic [1:0]  host_tag;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_tag;
  logic        busy, err_spurious;

  logic [1:0]  stub_resp = 2'b00;
  logic [31:0] stub_data = 32'h0;
  logic [1:0]  man_resp  = 2'b00;
  bit          stub_en   = 1'b1;
  int          calc1_reqs = 0;
  logic [3:0]  s_cmd, s_cmd2;
  logic [31:0] s_op1, s_op2;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  exp_t exp_q[$];

  assign out_resp = stub_resp | man_resp;
  assign out_data = stub_data;

  always #5 c_clk = ~c_clk;

  calc1_port_driver #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
    .c_clk(c_clk), .reset(reset),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_cmd(host_cmd), .host_op1(host_op1), .host_op2(host_op2), .host_tag(host_tag),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
    .out_resp(out_resp), .out_data(out_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_resp(rsp_resp), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .busy(busy), .err_spurious(err_spurious)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // calc1 behaviour used by the responder
  function automatic logic [33:0] calc1_eval(input logic [3:0] c, input logic [31:0] a,
                                             input logic [31:0] b);
    case (c)
      4'd1:    return {2'b01, a + b};
      4'd2:    return {2'b01, a - b};
      4'd5:    return {2'b01, a << b[4:0]};
      4'd6:    return {2'b01, a >> b[4:0]};
      default: return {2'b10, 32'h0};
    endcase
  endfunction

  // calc1 responder: observes SEND1/SEND2, answers two cycles into WAIT
  initial begin
    logic [33:0] r;
    forever begin
      @(negedge c_clk);
      if (reset && req_cmd_out != 4'd0) begin
        s_cmd = req_cmd_out;
        s_op1 = req_data_out;
        calc1_reqs++;
        @(negedge c_clk);
        s_cmd2 = req_cmd_out;
        s_op2  = req_data_out;
        if (stub_en) begin
          r = calc1_eval(s_cmd, s_op1, s_op2);
          @(posedge c_clk); #1;
          @(posedge c_clk); #1;
          stub_resp = r[33:32];
          stub_data = r[31:0];
          @(posedge c_clk); #1;
          stub_resp = 2'b00;
          stub_data = 32'h0;
        end
      end
    end
  end

  // scoreboard monitor: one pop per rsp handshake
  always @(negedge c_clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
        check("rsp_data", 64'(rsp_data), 64'(e.data));
        check("rsp_tag",  64'(rsp_tag),  64'(e.tag));
      end
    end
  end

  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] t, input bit push,
                      input logic [1:0] er, input logic [31:0] ed);
    bit accepted = 1'b0;
    bit ready_s;
    int n = 0;
    exp_t e;
    if (push) begin
      e.resp = er; e.data = ed; e.tag = t;
      exp_q.push_back(e);
    end
    host_valid = 1'b1; host_cmd = c; host_op1 = a; host_op2 = b; host_tag = t;
    while (!accepted && n < 300) begin
      ready_s = host_ready;
      @(posedge c_clk); #1;
      if (ready_s) accepted = 1'b1;
      n++;
    end
    host_valid = 1'b0;
    check("host_accept", 64'(accepted), 64'd1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge c_clk);
      n++;
    end
    check({"drain_", name}, 64'(exp_q.size()), 64'd0);
    @(posedge c_clk); #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_host_ready"}, 64'(host_ready), 64'd0);
    check({name, "_req_cmd"},    64'(req_cmd_out), 64'd0);
    check({name, "_req_data"},   64'(req_data_out), 64'd0);
    check({name, "_rsp_valid"},  64'(rsp_valid), 64'd0);
    check({name, "_rsp_resp"},   64'(rsp_resp), 64'd0);
    check({name, "_rsp_data"},   64'(rsp_data), 64'd0);
    check({name, "_rsp_tag"},    64'(rsp_tag), 64'd0);
    check({name, "_busy"},       64'(busy), 64'd0);
    check({name, "_err_spur"},   64'(err_spurious), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int r0;
    reset = 1'b0; host_valid = 1'b0; host_cmd = '0; host_op1 = '0; host_op2 = '0;
    host_tag = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge c_clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge c_clk); #1;
    check("ready_after_reset", 64'(host_ready), 64'd1);

    // add 5 + 7, tag 2; request appears on the 2nd cycle after acceptance
    rsp_ready = 1'b1;
    send(4'd1, 32'h5, 32'h7, 2'd2, 1'b1, 2'b01, 32'hC);
    n = 0;
    while (req_cmd_out == 4'd0 && n < 20) begin
      @(negedge c_clk);
      n++;
    end
    check("send1_latency", 64'(n), 64'd2);
    drain("add");
    check("send1_cmd",  64'(s_cmd),  64'd1);
    check("send1_data", 64'(s_op1),  64'h5);
    check("send2_cmd",  64'(s_cmd2), 64'd0);
    check("send2_data", 64'(s_op2),  64'h7);

    // cmd 0 completes locally, rsp two cycles after the pop
    rsp_ready = 1'b0;
    r0 = calc1_reqs;
    send(4'd0, 32'h1234, 32'h5678, 2'd3, 1'b1, 2'b10, 32'h0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge c_clk);
      n++;
    end
    check("cmd0_latency", 64'(n), 64'd3);
    check("cmd0_no_calc1", 64'(calc1_reqs), 64'(r0));
    rsp_ready = 1'b1;
    drain("cmd0");

    // A parks in HOLD, then a burst of five fills the FIFO after four
    rsp_ready = 1'b0;
    send(4'd1, 32'hFFFF_FFFF, 32'h1, 2'd0, 1'b1, 2'b01, 32'h0);
    n = 0;
    while (!rsp_valid && n < 30) begin
      @(negedge c_clk);
      n++;
    end
    check("hold_a", 64'(rsp_valid), 64'd1);
    @(posedge c_clk); #1;
    send(4'd1, 32'h3,  32'h4,  2'd1, 1'b1, 2'b01, 32'h7);
    send(4'd2, 32'h10, 32'h3,  2'd2, 1'b1, 2'b01, 32'hD);
    send(4'd5, 32'h1,  32'h4,  2'd3, 1'b1, 2'b01, 32'h10);
    send(4'd6, 32'h80, 32'h3,  2'd0, 1'b1, 2'b01, 32'h10);
    check("full_after_4", 64'(host_ready), 64'd0);
    fork
      send(4'd9, 32'hAA, 32'hBB, 2'd1, 1'b1, 2'b10, 32'h0);
      begin
        repeat (5) @(posedge c_clk);
        #1;
        check("full_held", 64'(host_ready), 64'd0);
        rsp_ready = 1'b1;
      end
    join
    drain("burst");

    // calc1 answer while IDLE is ignored and flagged
    man_resp = 2'b01;
    @(posedge c_clk); #1;
    man_resp = 2'b00;
    check("spurious_flag", 64'(err_spurious), 64'd1);
    repeat (3) @(posedge c_clk);
    #1;
    check("spurious_no_rsp", 64'(rsp_valid), 64'd0);
    check("spurious_sticky", 64'(err_spurious), 64'd1);

    // calc1 silent
    stub_en = 1'b0;
`ifdef CALC1_DRV_TIMEOUT_EN
    send(4'd1, 32'h1, 32'h2, 2'd2, 1'b1, 2'b11, 32'h0);
    drain("timeout");
`else
    send(4'd1, 32'h1, 32'h2, 2'd2, 1'b0, 2'b00, 32'h0);
    repeat (100) @(posedge c_clk);
    #1;
    check("wait_persists_valid", 64'(rsp_valid), 64'd0);
    check("wait_persists_busy",  64'(busy), 64'd1);
`endif

    // reset mid-operation discards in-flight and queued work
    send(4'd2, 32'h9, 32'h1, 2'd3, 1'b0, 2'b00, 32'h0);
    repeat (6) @(posedge c_clk);
    #1;
    check("busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b0;
    @(posedge c_clk); #1;
    check_all_zero("midreset");
    reset = 1'b1;
    @(posedge c_clk); #1;
    check("ready_after_midreset", 64'(host_ready), 64'd1);
    check("fifo_empty_after_reset", 64'(busy), 64'd0);
    man_resp = 2'b01;
    @(posedge c_clk); #1;
    man_resp = 2'b00;
    check("late_rsp_spurious", 64'(err_spurious), 64'd1);
    check("late_rsp_no_valid", 64'(rsp_valid), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/calc1_port_driver.md
CALC1_PORT_DRIVER -- requirements
Module: calc1_port_driver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, host command queue depth (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, WAIT-state cycle limit (used only when CALC1_DRV_TIMEOUT_EN is defined).
REQ-003 SHALL have port c_clk  in  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports host_valid in 1, host_ready out 1: command-accept handshake.
REQ-006 SHALL have ports host_cmd in 4, host_op1 in 32, host_op2 in 32, host_tag in 2: command and operands.
REQ-007 SHALL have ports req_cmd_out out 4, req_data_out out 32: drive one calc1 port's req_cmd_in/req_data_in.
REQ-008 SHALL have ports out_resp in 2, out_data in 32: from the same calc1 port.
REQ-009 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_resp out 2, rsp_data out 32, rsp_tag out 2: result handshake.
REQ-010 SHALL have ports busy out 1 (state not IDLE or FIFO not empty) and err_spurious out 1 (sticky).

Function
REQ-011 SHALL accept a command on a rising edge where host_valid and host_ready are both 1, writing {cmd, op1, op2, tag} into the FIFO.
REQ-012 SHALL drive host_ready = 1 iff FIFO not full at cycle start; no same-cycle bypass when full, even if a pop occurs.
REQ-013 SHALL implement FSM states IDLE, SEND1, SEND2, WAIT, HOLD; transitions: IDLE->SEND1 on FIFO non-empty (pop); SEND1->SEND2; SEND2->WAIT; WAIT->HOLD on out_resp != 0; HOLD->IDLE on rsp_ready.
REQ-014 SHALL, in SEND1, drive req_cmd_out = cmd and req_data_out = op1; in SEND2, req_cmd_out = 0 and req_data_out = op2; otherwise both 0.
REQ-015 SHALL register req_cmd_out/req_data_out; cmd/op1 appear no earlier than the 2nd cycle after the accepting edge.
REQ-016 SHALL keep at most one command outstanding per port; next SEND1 starts no earlier than the cycle after HOLD exits.
REQ-017 SHALL, in WAIT on out_resp != 0, capture out_resp, out_data and the command's tag; rsp_valid = 1 from the next cycle.
REQ-018 SHALL hold rsp_valid, rsp_resp, rsp_data and rsp_tag stable in HOLD until the rsp_ready edge; rsp_valid deasserts the next cycle.
REQ-019 SHALL complete a popped command with host_cmd = 0 without driving calc1: go to HOLD with rsp_resp = 2'b10, rsp_data = 0.
REQ-020 SHALL forward all other cmd values (1, 2, 5, 6 and invalid codes) unchanged; calc1 response is reported verbatim.
REQ-021 SHALL ignore out_resp != 0 outside WAIT and set err_spurious = 1 until reset.
REQ-022 SHALL preserve FIFO order; tags pass through unchecked.

Reset
REQ-023 SHALL, on a rising edge with reset = 0: FIFO empty, state IDLE, and host_ready, req_cmd_out, req_data_out, rsp_valid, rsp_resp, rsp_data, rsp_tag, busy and err_spurious all = 0.
REQ-024 SHALL drive host_ready = 1 from the first cycle after reset deasserts.
REQ-025 SHALL discard in-flight and queued commands on reset mid-operation; a late calc1 response then sets err_spurious.

Configuration
REQ-026 SHALL, with CALC1_DRV_TIMEOUT_EN defined, count WAIT cycles; at count = TIMEOUT_CYCLES with no response, enter HOLD with rsp_resp = 2'b11 and rsp_data = 0.
REQ-027 SHALL, without CALC1_DRV_TIMEOUT_EN, have no counter; WAIT persists until a response.

Verification
REQ-028 SHALL cover: add cmd 1, op1 = 0x5, op2 = 0x7, tag 2 -> SEND1 drives 1/0x5, SEND2 drives 0/0x7; calc1 resp 01/0xC -> rsp 01, 0xC, tag 2.
REQ-029 SHALL cover: 5 back-to-back commands, rsp_ready = 0 -> host_ready low after 4th accept; results in order after rsp_ready rises.
REQ-030 SHALL cover: host_cmd = 0 -> no calc1 activity; rsp_resp = 10, rsp_data = 0 two cycles after the pop.
REQ-031 SHALL cover: out_resp = 01 forced in IDLE -> err_spurious = 1, rsp_valid stays 0.
REQ-032 SHALL cover: reset low in WAIT -> all outputs 0 next cycle, FIFO empty.
REQ-033 SHALL cover (timeout build): no response for 64 WAIT cycles -> rsp_resp = 11, rsp_data = 0.
